// File: rtl/tree_pkg.sv
// tree_pkg -- shared definitions for the decision-tree walker.
//   Node word field positions (120-bit node word), the tag value that marks
//   an internal node, and the walker FSM state type.
package tree_pkg;

  // Node word layout: [119:108] zero, [107:96] id, [95:92] feature index,
  // [91:28] threshold, [27:16] left child, [15:4] right child, [3:0] tag.
  localparam int ID_MSB    = 107;
  localparam int ID_LSB    = 96;
  localparam int FIDX_MSB  = 95;
  localparam int FIDX_LSB  = 92;
  localparam int THR_MSB   = 91;
  localparam int THR_LSB   = 28;
  localparam int LEFT_MSB  = 27;
  localparam int LEFT_LSB  = 16;
  localparam int RIGHT_MSB = 15;
  localparam int RIGHT_LSB = 4;
  localparam int TAG_MSB   = 3;
  localparam int TAG_LSB   = 0;

  localparam logic [3:0] TAG_INTERNAL = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp64_le.sv
// fp64_le -- combinational "a <= b" for IEEE-754 doubles.
//   a  : in  64  left operand
//   b  : in  64  right operand
//   le : out 1   high when a <= b
// Sign-magnitude ordering: -0 and +0 are equal; when both operands are
// negative the magnitude order is reversed. NaN inputs give an arbitrary but
// deterministic answer.
module fp64_le (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);

  logic [62:0] mag_a;
  logic [62:0] mag_b;

  assign mag_a = a[62:0];
  assign mag_b = b[62:0];

  always_comb begin
    le = 1'b0;
    if (mag_a == 63'd0 && mag_b == 63'd0) begin
      le = 1'b1;                    // +0 / -0 in any combination
    end else if (a[63] != b[63]) begin
      le = a[63];                   // negative side is the smaller one
    end else if (!a[63]) begin
      le = (mag_a <= mag_b);
    end else begin
      le = (mag_a >= mag_b);        // both negative: larger magnitude is smaller
    end
  end

endmodule

// File: rtl/tree_walker.sv
// tree_walker -- walks a binary decision tree stored in an external node ROM
// for one sample of NUM_FEATURES doubles and returns the leaf class.
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid/s_ready          : sample handshake, s_features = NUM_FEATURES x 64-bit doubles
//   rom_addr/rom_data        : external node ROM, data valid one cycle after address
//   r_valid/r_ready          : result handshake
//   r_class/r_error/r_depth  : leaf class, traversal aborted, internal nodes visited
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The sample side is ready only in IDLE, so one sample is in flight
// at a time. The result side holds r_valid and its payload steady until
// r_ready is seen high.
module tree_walker
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_FEATURES = 16,
  parameter int MAX_DEPTH    = 32,
  parameter int ROOT_ADDR    = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_FEATURES*64-1:0]   s_features,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [NODE_WIDTH-1:0]        rom_data,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic                         r_class,
  output logic                         r_error,
  output logic [5:0]                   r_depth
);

  localparam logic [5:0] MAX_D = 6'(MAX_DEPTH);

  state_t                       state;
  logic [NUM_FEATURES*64-1:0]   features;
  logic [5:0]                   depth;

  // rom_addr doubles as the current-node register: it is loaded with the
  // next node whenever the walker leaves IDLE or an internal EVAL, so it is
  // already stable throughout ISSUE and the ROM answers during EVAL.

  logic [11:0] node_id;
  logic [3:0]  fidx;
  logic [63:0] threshold;
  logic [11:0] left_raw;
  logic [11:0] right_raw;
  logic [3:0]  tag;

  assign node_id   = rom_data[ID_MSB:ID_LSB];
  assign fidx      = rom_data[FIDX_MSB:FIDX_LSB];
  assign threshold = rom_data[THR_MSB:THR_LSB];
  assign left_raw  = rom_data[LEFT_MSB:LEFT_LSB];
  assign right_raw = rom_data[RIGHT_MSB:RIGHT_LSB];
  assign tag       = rom_data[TAG_MSB:TAG_LSB];

  // 12-bit node fields are zero-extended then cut to the address width, so
  // wide address buses see the field in their low bits and narrow ones
  // simply drop the upper field bits.
  logic [31:0]           id_ext;
  logic [31:0]           left_ext;
  logic [31:0]           right_ext;
  logic [ADDR_WIDTH-1:0] id_addr;
  logic [ADDR_WIDTH-1:0] left_addr;
  logic [ADDR_WIDTH-1:0] right_addr;

  assign id_ext     = {20'd0, node_id};
  assign left_ext   = {20'd0, left_raw};
  assign right_ext  = {20'd0, right_raw};
  assign id_addr    = id_ext[ADDR_WIDTH-1:0];
  assign left_addr  = left_ext[ADDR_WIDTH-1:0];
  assign right_addr = right_ext[ADDR_WIDTH-1:0];

  logic [63:0] feat_val;
  logic        fidx_bad;
  logic        is_internal;
  logic        bad_node;
  logic        go_left;

  assign feat_val    = features[{fidx, 6'd0} +: 64];
  assign fidx_bad    = ({28'd0, fidx} >= 32'(NUM_FEATURES));
  assign is_internal = (tag == TAG_INTERNAL);
  // A node that is not where we expected it, names a missing feature, or
  // would push the walk past the depth limit aborts the traversal.
  assign bad_node    = (id_addr != rom_addr) || fidx_bad ||
                       (is_internal && depth == MAX_D);

  fp64_le u_le (
    .a  (feat_val),
    .b  (threshold),
    .le (go_left)
  );

  assign s_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      features <= '0;
      depth    <= 6'd0;
      r_valid  <= 1'b0;
      r_class  <= 1'b0;
      r_error  <= 1'b0;
      r_depth  <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            features <= s_features;
            rom_addr <= ADDR_WIDTH'(ROOT_ADDR);
            depth    <= 6'd0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= EVAL;
        end
        EVAL: begin
          if (bad_node) begin
            r_valid <= 1'b1;
            r_error <= 1'b1;
            r_class <= 1'b0;
            r_depth <= depth;
            state   <= DONE;
          end else if (!is_internal) begin
            r_valid <= 1'b1;
            r_error <= 1'b0;
            r_class <= tag[0];
            r_depth <= depth;
            state   <= DONE;
          end else begin
            rom_addr <= go_left ? left_addr : right_addr;
            depth    <= depth + 6'd1;
            state    <= ISSUE;
          end
        end
        DONE: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_walker.sv
// tb_tree_walker -- directed self-checking bench for tree_walker with a
// registered-read node ROM model.
module tb_tree_walker;

  localparam int NF = 16;

  logic           clk;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [NF*64-1:0] s_features;
  logic [9:0]     rom_addr;
  logic [119:0]   rom_data;
  logic           r_valid;
  logic           r_ready;
  logic           r_class;
  logic           r_error;
  logic [5:0]     r_depth;

  logic [119:0]   rom_mem [0:1023];

  int checks = 0;
  int errors = 0;

  tree_walker dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_features (s_features),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_class    (r_class),
    .r_error    (r_error),
    .r_depth    (r_depth)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // node ROM: data one cycle after address
  always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

  function automatic logic [119:0] mk_int(input logic [11:0] id, input logic [3:0] f,
                                          input logic [63:0] thr, input logic [11:0] l,
                                          input logic [11:0] r);
    return {12'h0, id, f, thr, l, r, 4'h3};
  endfunction

  function automatic logic [119:0] mk_leaf(input logic [11:0] id, input logic [3:0] tag);
    return {12'h0, id, 4'h0, 64'h0, 12'h0, 12'h0, tag};
  endfunction

  // driver tasks
  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
  endtask

  // returns at #1 after the handshake edge, i.e. in cycle 1
  task automatic send(input logic [NF*64-1:0] f);
    int guard;
    guard = 0;
    @(negedge clk);
    s_features = f;
    s_valid = 1'b1;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: s_ready=%0b want 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 1;
    while (r_valid !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (r_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: r_valid=%0b after %0d cycles want 1", r_valid, cyc);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
  endtask

  function automatic logic [NF*64-1:0] feats(input int idx, input logic [63:0] v);
    logic [NF*64-1:0] f;
    for (int i = 0; i < NF; i++) f[i*64 +: 64] = 64'h4059_0000_0000_0000 + 64'(i); // ~100.0 filler
    f[idx*64 +: 64] = v;
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    r_ready = 1'b0;
    s_features = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %0b want 0", r_valid); end
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL reset_r_class: got %0b want 0", r_class); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL reset_r_error: got %0b want 0", r_error); end
    checks++; if (r_depth !== 6'd0) begin errors++; $display("FAIL reset_r_depth: got %0d want 0", r_depth); end
    checks++; if (rom_addr !== 10'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    rst = 1'b0;
  endtask

  task automatic test_root_leaf();
    int cyc;
    clear_rom();
    rom_mem[0] = mk_leaf(12'd0, 4'h1);
    send(feats(0, 64'h0));
    wait_result(cyc);
    checks++; if (cyc != 3) begin errors++; $display("FAIL root_leaf_latency: got cycle %0d want 3", cyc); end
    checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL root_leaf_class: got %0b want 1", r_class); end
    checks++; if (r_depth !== 6'd0) begin errors++; $display("FAIL root_leaf_depth: got %0d want 0", r_depth); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL root_leaf_error: got %0b want 0", r_error); end
    consume();
  endtask

  task automatic load_thr_tree(input logic [3:0] f, input logic [63:0] thr);
    clear_rom();
    rom_mem[0] = mk_int(12'd0, f, thr, 12'd1, 12'd2);
    rom_mem[1] = mk_leaf(12'd1, 4'h2);  // class 0
    rom_mem[2] = mk_leaf(12'd2, 4'h5);  // class 1
  endtask

  task automatic test_threshold();
    int cyc;
    load_thr_tree(4'd0, 64'h3FF0_0000_0000_0000);
    send(feats(0, 64'h3FF0_0000_0000_0000));
    wait_result(cyc);
    checks++; if (cyc != 5) begin errors++; $display("FAIL thr_eq_latency: got cycle %0d want 5", cyc); end
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL thr_eq_class: got %0b want 0", r_class); end
    checks++; if (r_depth !== 6'd1) begin errors++; $display("FAIL thr_eq_depth: got %0d want 1", r_depth); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL thr_eq_error: got %0b want 0", r_error); end
    consume();
    send(feats(0, 64'h3FF0_0000_0000_0001));
    wait_result(cyc);
    checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL thr_above_class: got %0b want 1", r_class); end
    checks++; if (r_depth !== 6'd1) begin errors++; $display("FAIL thr_above_depth: got %0d want 1", r_depth); end
    consume();
  endtask

  task automatic test_negative();
    int cyc;
    load_thr_tree(4'd5, 64'hC000_0000_0000_0000);      // -2.0
    send(feats(5, 64'hC008_0000_0000_0000));            // -3.0 -> left
    wait_result(cyc);
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL neg_left_class: got %0b want 0", r_class); end
    consume();
    send(feats(5, 64'hBFF0_0000_0000_0000));            // -1.0 -> right
    wait_result(cyc);
    checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL neg_right_class: got %0b want 1", r_class); end
    consume();
    load_thr_tree(4'd5, 64'h0000_0000_0000_0000);      // +0.0
    send(feats(5, 64'h8000_0000_0000_0000));            // -0.0 -> left
    wait_result(cyc);
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL zero_left_class: got %0b want 0", r_class); end
    consume();
    send(feats(5, 64'h0000_0000_0000_0001));            // tiny positive -> right
    wait_result(cyc);
    checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL zero_right_class: got %0b want 1", r_class); end
    consume();
  endtask

  task automatic test_cycle();
    int cyc;
    clear_rom();
    rom_mem[0] = mk_int(12'd0, 4'd0, 64'h0, 12'd1, 12'd1);
    rom_mem[1] = mk_int(12'd1, 4'd0, 64'h0, 12'd1, 12'd1);
    send(feats(0, 64'h3FF0_0000_0000_0000));
    wait_result(cyc);
    checks++; if (r_error !== 1'b1) begin errors++; $display("FAIL cycle_error: got %0b want 1", r_error); end
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL cycle_class: got %0b want 0", r_class); end
    checks++; if (r_depth !== 6'd32) begin errors++; $display("FAIL cycle_depth: got %0d want 32", r_depth); end
    checks++; if (cyc != 67) begin errors++; $display("FAIL cycle_latency: got cycle %0d want 67", cyc); end
    consume();
  endtask

  task automatic test_id_mismatch();
    int cyc;
    clear_rom();
    rom_mem[0] = mk_int(12'd0, 4'd0, 64'h0, 12'd2, 12'd2);
    rom_mem[2] = mk_leaf(12'd7, 4'h1);
    send(feats(0, 64'h0));
    wait_result(cyc);
    checks++; if (r_error !== 1'b1) begin errors++; $display("FAIL idmis_error: got %0b want 1", r_error); end
    checks++; if (r_class !== 1'b0) begin errors++; $display("FAIL idmis_class: got %0b want 0", r_class); end
    checks++; if (r_depth !== 6'd1) begin errors++; $display("FAIL idmis_depth: got %0d want 1", r_depth); end
    checks++; if (cyc != 5) begin errors++; $display("FAIL idmis_latency: got cycle %0d want 5", cyc); end
    consume();
  endtask

  task automatic test_back_to_back_hold();
    int cyc;
    int extra;
    load_thr_tree(4'd0, 64'h3FF0_0000_0000_0000);
    send(feats(0, 64'h4000_0000_0000_0000));            // 2.0 -> right, class 1
    wait_result(cyc);
    @(negedge clk);
    s_features = feats(0, 64'h0);
    s_valid = 1'b1;                                      // next sample offered while busy
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (r_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %0b want 1", i, r_valid); end
      checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL hold_class[%0d]: got %0b want 1", i, r_class); end
      checks++; if (r_depth !== 6'd1) begin errors++; $display("FAIL hold_depth[%0d]: got %0d want 1", i, r_depth); end
      checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL hold_error[%0d]: got %0b want 0", i, r_error); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hold_s_ready[%0d]: got %0b want 0", i, s_ready); end
    end
    @(negedge clk);
    s_valid = 1'b0;
    r_ready = 1'b1;
    @(posedge clk);
    #1;
    r_ready = 1'b0;
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL hold_consumed: r_valid=%0b want 0", r_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hold_idle: s_ready=%0b want 1", s_ready); end
    extra = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (r_valid !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL hold_single: extra r_valid cycles=%0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int spurious;
    clear_rom();
    rom_mem[0] = mk_int(12'd0, 4'd0, 64'h3FF0_0000_0000_0000, 12'd1, 12'd1);
    rom_mem[1] = mk_int(12'd1, 4'd0, 64'h3FF0_0000_0000_0000, 12'd3, 12'd3);
    rom_mem[3] = mk_leaf(12'd3, 4'h1);
    send(feats(0, 64'h0));                              // now in cycle 1
    repeat (3) @(posedge clk);
    #1;                                                 // cycle 4: EVAL of node 1
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready: got %0b want 1", s_ready); end
    checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL rstmid_r_valid: got %0b want 0", r_valid); end
    spurious = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (r_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_result: r_valid cycles=%0d want 0", spurious); end
    send(feats(0, 64'h4000_0000_0000_0000));
    wait_result(cyc);
    checks++; if (cyc != 7) begin errors++; $display("FAIL rstmid_next_latency: got cycle %0d want 7", cyc); end
    checks++; if (r_class !== 1'b1) begin errors++; $display("FAIL rstmid_next_class: got %0b want 1", r_class); end
    checks++; if (r_depth !== 6'd2) begin errors++; $display("FAIL rstmid_next_depth: got %0d want 2", r_depth); end
    checks++; if (r_error !== 1'b0) begin errors++; $display("FAIL rstmid_next_error: got %0b want 0", r_error); end
    consume();
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_root_leaf();
    test_threshold();
    test_negative();
    test_cycle();
    test_id_mismatch();
    test_back_to_back_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
